ucsbece154b_perfmon: RTL and testbench

UCSBECE154B_PERFMON -- requirements
Module: ucsbece154b_perfmon

---
 rtl/ucsbece154b_perf_pkg.sv | 23 ++
 rtl/ucsbece154b_perf_counter.sv | 34 +++
 rtl/ucsbece154b_perfmon.sv | 140 ++++++++++++++
 tb/tb_ucsbece154b_perfmon.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ucsbece154b_perf_pkg.sv
// Shared definitions for the performance monitor: FSM encoding and counter indices.
// Latency: n/a. Backpressure: n/a.
`timescale 1ns/1ps
package ucsbece154b_perf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam int CNT_CYCLES   = 0;
    localparam int CNT_INSTRS   = 1;
    localparam int CNT_BRANCH   = 2;
    localparam int CNT_BR_MISS  = 3;
    localparam int CNT_JUMP     = 4;
    localparam int CNT_JMP_MISS = 5;
    localparam int CNT_STALL    = 6;
    localparam int NUM_CNT      = 7;

    localparam logic [2:0] SEL_ZERO = 3'd7;

endpackage

// File: rtl/ucsbece154b_perf_counter.sv
// Single event counter with clear, saturating or wrapping add; count is 1 cycle after inc.
// Backpressure: none, an increment is always accepted.
`timescale 1ns/1ps
module ucsbece154b_perf_counter #(
    parameter int CW  = 32,
    parameter int SAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic [CW-1:0] inc,
    output logic [CW-1:0] count,
    output logic          ovf
);

    logic [CW:0] sum;

    // One extra bit so a carry out is visible before truncation.
    assign sum = {1'b0, count} + {1'b0, inc};
    assign ovf = sum[CW];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (sum[CW] && (SAT != 0)) begin
            count <= '1;
        end else begin
            count <= sum[CW-1:0];
        end
    end

endmodule

// File: rtl/ucsbece154b_perfmon.sv
// Run-controlled pipeline event counters with a registered read mux; rdata_o lags sel_i by 1 cycle.
// Backpressure: none, events are sampled every RUN cycle.
`timescale 1ns/1ps
module ucsbece154b_perfmon
    import ucsbece154b_perf_pkg::*;
#(
    parameter int NSLOT       = 2,
    parameter int CW          = 32,
    parameter int SAT         = 1,
    parameter int HALT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [NSLOT-1:0] valid_i,
    input  logic [NSLOT-1:0] isbranch_i,
    input  logic [NSLOT-1:0] isjump_i,
    input  logic [NSLOT-1:0] mispredict_i,
    input  logic             stall_i,
    input  logic             halt_i,
    input  logic [2:0]       sel_i,
    output logic [CW-1:0]    rdata_o,
    output logic [1:0]       state_o,
    output logic             done_o,
    output logic             ovf_o
);

    localparam int HW = (HALT_CYCLES < 1) ? 1 : $clog2(HALT_CYCLES + 1);

    state_t             state, state_nxt;
    logic               run;
    logic               clear;
    logic [HW-1:0]      halt_run;
    logic [HW:0]        halt_inc;
    logic               halt_hit;
    logic [CW-1:0]      inc [NUM_CNT];
    logic [CW-1:0]      cnt [NUM_CNT];
    logic [NUM_CNT-1:0] cnt_ovf;
    logic [CW-1:0]      rd_mux;

    assign run   = (state == ST_RUN);
    // Only a start that actually enters RUN (from IDLE or DONE) wipes the run.
    assign clear = (state != ST_RUN) && start_i;

    assign halt_inc = {1'b0, halt_run} + 1'b1;
    assign halt_hit = run && halt_i && (halt_inc >= (HW+1)'(HALT_CYCLES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start_i)             state_nxt = ST_RUN;
            ST_RUN:  if (stop_i || halt_hit)  state_nxt = ST_DONE;
            ST_DONE: if (start_i)             state_nxt = ST_RUN;
            default:                          state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halt_run <= '0;
        end else if (clear) begin
            halt_run <= '0;
        end else if (run) begin
            halt_run <= halt_i ? halt_inc[HW-1:0] : '0;
        end
    end

    // Per-cycle increments; all zero outside RUN so counters hold.
    always_comb begin
        for (int i = 0; i < NUM_CNT; i++) begin
            inc[i] = '0;
        end
        if (run) begin
            inc[CNT_CYCLES] = CW'(1);
            inc[CNT_STALL]  = CW'(stall_i);
            for (int k = 0; k < NSLOT; k++) begin
                inc[CNT_INSTRS] = inc[CNT_INSTRS] + CW'(valid_i[k]);
                if (isbranch_i[k]) begin
                    inc[CNT_BRANCH]  = inc[CNT_BRANCH] + CW'(1);
                    inc[CNT_BR_MISS] = inc[CNT_BR_MISS] + CW'(mispredict_i[k]);
                end else if (isjump_i[k]) begin
                    inc[CNT_JUMP]     = inc[CNT_JUMP] + CW'(1);
                    inc[CNT_JMP_MISS] = inc[CNT_JMP_MISS] + CW'(mispredict_i[k]);
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
        ucsbece154b_perf_counter #(
            .CW  (CW),
            .SAT (SAT)
        ) u_cnt (
            .clk   (clk),
            .reset (reset),
            .clear (clear),
            .inc   (inc[g]),
            .count (cnt[g]),
            .ovf   (cnt_ovf[g])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_o <= 1'b0;
        end else if (clear) begin
            ovf_o <= 1'b0;
        end else if (|cnt_ovf) begin
            ovf_o <= 1'b1;
        end
    end

    always_comb begin
        rd_mux = '0;
        if (sel_i != SEL_ZERO) begin
            rd_mux = cnt[sel_i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_o <= '0;
        end else begin
            rdata_o <= rd_mux;
        end
    end

    assign state_o = state;
    assign done_o  = (state == ST_DONE);

endmodule

// File: tb/tb_ucsbece154b_perfmon.sv
// Scoreboard bench: three monitor instances (32-bit saturating, 4-bit saturating, 4-bit wrapping)
// share one stimulus stream and are checked against an unbounded-count reference model.
`timescale 1ns/1ps
module tb_ucsbece154b_perfmon;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_i, stop_i, stall_i, halt_i;
    logic [1:0] valid_i, isbranch_i, isjump_i, mispredict_i;
    logic [2:0] sel_i;

    logic [31:0] rd_m;
    logic [3:0]  rd_s, rd_w;
    logic [1:0]  st_m, st_s, st_w;
    logic        dn_m, dn_s, dn_w;
    logic        ov_m, ov_s, ov_w;

    always #5 clk = ~clk;

    ucsbece154b_perfmon u_main (
        .clk(clk), .reset(reset), .start_i(start_i), .stop_i(stop_i),
        .valid_i(valid_i), .isbranch_i(isbranch_i), .isjump_i(isjump_i),
        .mispredict_i(mispredict_i), .stall_i(stall_i), .halt_i(halt_i),
        .sel_i(sel_i), .rdata_o(rd_m), .state_o(st_m), .done_o(dn_m), .ovf_o(ov_m)
    );

    ucsbece154b_perfmon #(.CW(4), .SAT(1)) u_sat (
        .clk(clk), .reset(reset), .start_i(start_i), .stop_i(stop_i),
        .valid_i(valid_i), .isbranch_i(isbranch_i), .isjump_i(isjump_i),
        .mispredict_i(mispredict_i), .stall_i(stall_i), .halt_i(halt_i),
        .sel_i(sel_i), .rdata_o(rd_s), .state_o(st_s), .done_o(dn_s), .ovf_o(ov_s)
    );

    ucsbece154b_perfmon #(.CW(4), .SAT(0)) u_wrap (
        .clk(clk), .reset(reset), .start_i(start_i), .stop_i(stop_i),
        .valid_i(valid_i), .isbranch_i(isbranch_i), .isjump_i(isjump_i),
        .mispredict_i(mispredict_i), .stall_i(stall_i), .halt_i(halt_i),
        .sel_i(sel_i), .rdata_o(rd_w), .state_o(st_w), .done_o(dn_w), .ovf_o(ov_w)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: true (unbounded) event totals; width effects applied on read.
    longint tc[7];
    int     ms;     // 0 idle, 1 run, 2 done
    int     hrun;

    typedef struct {
        int     inst;
        int     sel;
        longint exp;
    } rd_t;
    rd_t sbq[$];

    logic rd_req = 1'b0;
    logic rd_req_q = 1'b0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int inst_cw(input int inst);
        return (inst == 0) ? 32 : 4;
    endfunction

    function automatic longint expv(input int inst, input int sel);
        longint m;
        if (sel == 7) return 0;
        m = (64'd1 << inst_cw(inst)) - 1;
        if (inst == 2) return tc[sel] & m;
        return (tc[sel] > m) ? m : tc[sel];
    endfunction

    function automatic longint exp_ovf(input int inst);
        longint m;
        m = (64'd1 << inst_cw(inst)) - 1;
        for (int k = 0; k < 7; k++) begin
            if (tc[k] > m) return 1;
        end
        return 0;
    endfunction

    function automatic longint rd_of(input int inst);
        if (inst == 0) return longint'(rd_m);
        if (inst == 1) return longint'(rd_s);
        return longint'(rd_w);
    endfunction

    // Monitor: one registered read result per instance appears the cycle after a request.
    always @(posedge clk) rd_req_q <= rd_req;

    always @(negedge clk) begin
        if (rd_req_q) begin
            for (int i = 0; i < 3; i++) begin
                if (sbq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_underflow: got empty queue expected entry");
                end else begin
                    rd_t e;
                    e = sbq.pop_front();
                    chk($sformatf("rdata inst%0d sel%0d", e.inst, e.sel), rd_of(e.inst), e.exp);
                end
            end
        end
    end

    task automatic model_reset();
        for (int k = 0; k < 7; k++) tc[k] = 0;
        ms = 0;
        hrun = 0;
    endtask

    task automatic idle_inputs();
        start_i = 0; stop_i = 0; stall_i = 0; halt_i = 0;
        valid_i = 0; isbranch_i = 0; isjump_i = 0; mispredict_i = 0;
    endtask

    // Apply the model for the inputs currently driven, then advance one clock.
    task automatic step();
        if (ms == 1) begin
            tc[0]++;
            for (int k = 0; k < 2; k++) begin
                tc[1] += valid_i[k];
                if (isbranch_i[k]) begin
                    tc[2]++;
                    tc[3] += mispredict_i[k];
                end else if (isjump_i[k]) begin
                    tc[4]++;
                    tc[5] += mispredict_i[k];
                end
            end
            tc[6] += stall_i;
            hrun = halt_i ? hrun + 1 : 0;
            if (stop_i || hrun >= 2) ms = 2;
        end else if (start_i) begin
            for (int k = 0; k < 7; k++) tc[k] = 0;
            hrun = 0;
            ms = 1;
        end
        @(posedge clk);
        @(negedge clk);
        chk("state", st_m, ms);
        chk("done", dn_m, (ms == 2) ? 1 : 0);
    endtask

    task automatic push3(input int s, input longint e0, input longint e1, input longint e2);
        rd_t e;
        e.sel = s;
        e.inst = 0; e.exp = e0; sbq.push_back(e);
        e.inst = 1; e.exp = e1; sbq.push_back(e);
        e.inst = 2; e.exp = e2; sbq.push_back(e);
    endtask

    task automatic read_all();
        idle_inputs();
        for (int s = 0; s < 8; s++) begin
            sel_i = 3'(s);
            rd_req = 1;
            push3(s, expv(0, s), expv(1, s), expv(2, s));
            step();
        end
        rd_req = 0;
        step();
        chk("ovf main", ov_m, exp_ovf(0));
        chk("ovf sat4", ov_s, exp_ovf(1));
        chk("ovf wrap4", ov_w, exp_ovf(2));
    endtask

    task automatic read_lit(input int s, input longint e0, input longint e1, input longint e2);
        idle_inputs();
        sel_i = 3'(s);
        rd_req = 1;
        push3(s, e0, e1, e2);
        step();
        rd_req = 0;
        step();
    endtask

    task automatic start_run();
        idle_inputs();
        start_i = 1;
        step();
        start_i = 0;
    endtask

    task automatic random_run(input int maxc);
        start_run();
        for (int i = 0; i < maxc; i++) begin
            valid_i      = 2'($urandom_range(0, 3));
            isbranch_i   = 2'($urandom_range(0, 3));
            isjump_i     = 2'($urandom_range(0, 3));
            mispredict_i = 2'($urandom_range(0, 3));
            stall_i      = ($urandom_range(0, 2) == 0);
            halt_i       = ($urandom_range(0, 3) == 0);
            start_i      = ($urandom_range(0, 7) == 0);
            stop_i       = ($urandom_range(0, 29) == 0) || (i == maxc - 1);
            step();
            if (ms == 2) break;
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        sel_i = 0;
        model_reset();
        #2;
        chk("reset state", st_m, 0);
        chk("reset done", dn_m, 0);
        chk("reset ovf", ov_m, 0);
        chk("reset rdata", rd_m, 0);
        chk("reset state sat4", st_s, 0);
        chk("reset rdata wrap4", rd_w, 0);
        @(negedge clk);
        reset = 0;
        read_all();

        // Ten dual-issue cycles then a two-cycle halt ends the run.
        start_run();
        valid_i = 2'b11;
        for (int i = 0; i < 10; i++) step();
        valid_i = 2'b00;
        halt_i = 1;
        step();
        chk("halt1 still run", st_m, 1);
        step();
        chk("halt2 done", st_m, 2);
        read_lit(0, 12, 12, 12);
        read_lit(1, 20, 15, 4);
        read_all();

        // Mispredicted branch on slot 0, clean JAL on slot 1.
        start_run();
        isbranch_i = 2'b01; mispredict_i = 2'b01;
        step();
        idle_inputs();
        isjump_i = 2'b10;
        step();
        idle_inputs();
        stop_i = 1;
        step();
        read_lit(2, 1, 1, 1);
        read_lit(3, 1, 1, 1);
        read_lit(4, 1, 1, 1);
        read_lit(5, 0, 0, 0);
        read_all();

        // Nine dual-issue cycles: 18 instructions overflow a 4-bit counter.
        start_run();
        valid_i = 2'b11;
        for (int i = 0; i < 8; i++) step();
        stop_i = 1;
        step();
        read_lit(1, 18, 15, 2);
        chk("ovf sat4 lit", ov_s, 1);
        chk("ovf wrap4 lit", ov_w, 1);
        chk("ovf main lit", ov_m, 0);
        read_all();

        // Broken halt pattern 1,0,1,1.
        start_run();
        halt_i = 1; step(); chk("halt pat 1", st_m, 1);
        halt_i = 0; step(); chk("halt pat 0", st_m, 1);
        halt_i = 1; step(); chk("halt pat 1b", st_m, 1);
        halt_i = 1; step(); chk("halt pat 1c", st_m, 2);
        read_all();

        // start and stop together in RUN: stop wins.
        start_run();
        start_i = 1; stop_i = 1;
        step();
        chk("start+stop", st_m, 2);
        read_all();

        // Reset in the middle of a run.
        start_run();
        valid_i = 2'b11; stall_i = 1;
        step(); step(); step();
        idle_inputs();
        reset = 1;
        #2;
        chk("midrun reset state", st_m, 0);
        chk("midrun reset ovf", ov_m, 0);
        chk("midrun reset rdata", rd_m, 0);
        model_reset();
        @(negedge clk);
        reset = 0;
        read_all();

        // Restart from DONE clears the previous run's totals.
        random_run(30);
        read_all();
        start_run();
        valid_i = 2'b01; isjump_i = 2'b01; mispredict_i = 2'b01; stop_i = 1;
        step();
        read_all();

        for (int r = 0; r < 10; r++) begin
            random_run(40);
            read_all();
        end

        repeat (3) @(negedge clk);
        chk("scoreboard empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
